// File: rtl/spi_slave_reg_bridge.sv
// rtl/spi_slave_reg_bridge.sv - SPI responder bridging command/burst frames onto a parallel register bus
// SPI pins are oversampled in clk; the first byte of a frame selects read/write and start address.
module spi_slave_reg_bridge #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  DUMMY_BYTE  = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       sck,
  input  logic       ssn,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic [6:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       frame_abort
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RDUMMY,
    ST_RDATA
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ssn_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   cpol_l;
  logic                   cpha_l;
  logic [2:0]             bit_cnt;
  logic [6:0]             rx_sr;
  logic [7:0]             tx_sr;
  logic                   tx_bit;
  logic [7:0]             rd_buf;
  logic                   cap_pend;
  logic                   inc_pend;

  logic       ssn_q;
  logic       mosi_q;
  logic       sck_rise;
  logic       sck_fall;
  logic       lead_edge;
  logic       trail_edge;
  logic       sample_edge;
  logic       shift_edge;
  logic       byte_done;
  logic [7:0] rx_byte;

  // ssn synchroniser resets high so the pad is not driven until a real select arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      ssn_sync  <= '1;
      mosi_sync <= '0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      ssn_sync  <= {ssn_sync[SYNC_STAGES-2:0], ssn};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign ssn_q       = ssn_sync[SYNC_STAGES-1];
  assign mosi_q      = mosi_sync[SYNC_STAGES-1];
  assign sck_rise    = sck_sync[SYNC_STAGES-2] & ~sck_sync[SYNC_STAGES-1];
  assign sck_fall    = ~sck_sync[SYNC_STAGES-2] & sck_sync[SYNC_STAGES-1];
  assign lead_edge   = cpol_l ? sck_fall : sck_rise;
  assign trail_edge  = cpol_l ? sck_rise : sck_fall;
  assign sample_edge = cpha_l ? trail_edge : lead_edge;
  assign shift_edge  = cpha_l ? lead_edge : trail_edge;
  assign rx_byte     = {rx_sr, mosi_q};
  assign byte_done   = sample_edge && (bit_cnt == 3'd7);

  assign miso_oe = ~ssn_q;
  assign miso    = miso_oe & (cpha_l ? tx_bit : tx_sr[7]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cpol_l      <= 1'b0;
      cpha_l      <= 1'b0;
      bit_cnt     <= 3'd0;
      rx_sr       <= 7'd0;
      tx_sr       <= 8'd0;
      tx_bit      <= 1'b0;
      rd_buf      <= 8'd0;
      cap_pend    <= 1'b0;
      inc_pend    <= 1'b0;
      reg_addr    <= 7'd0;
      reg_wdata   <= 8'd0;
      reg_we      <= 1'b0;
      reg_re      <= 1'b0;
      busy        <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      reg_we      <= 1'b0;
      reg_re      <= 1'b0;
      frame_abort <= 1'b0;
      cap_pend    <= reg_re;
      inc_pend    <= 1'b0;

      // read data arrives the clk after the strobe; address advances one clk later
      if (cap_pend) begin
        rd_buf   <= reg_rdata;
        inc_pend <= 1'b1;
      end
      if (inc_pend) begin
        reg_addr <= reg_addr + 7'd1;
      end

      if (state == ST_IDLE) begin
        bit_cnt <= 3'd0;
        if (!ssn_q) begin
          state  <= ST_CMD;
          busy   <= 1'b1;
          cpol_l <= cpol;
          cpha_l <= cpha;
          tx_sr  <= DUMMY_BYTE;
          tx_bit <= 1'b0;
        end
      end else if (ssn_q) begin
        // deselect: a byte finishing on this very clk still counts, a partial one is dropped
        state       <= ST_IDLE;
        busy        <= 1'b0;
        bit_cnt     <= 3'd0;
        rx_sr       <= 7'd0;
        tx_sr       <= DUMMY_BYTE;
        tx_bit      <= 1'b0;
        frame_abort <= (bit_cnt != 3'd0) && !byte_done;
        if (byte_done && state == ST_WDATA) begin
          reg_wdata <= rx_byte;
          reg_we    <= 1'b1;
          inc_pend  <= 1'b1;
        end else if (byte_done && state == ST_CMD) begin
          reg_addr <= rx_byte[6:0];
        end
      end else begin
        if (shift_edge) begin
          if (cpha_l) begin
            tx_bit <= tx_sr[7];
            tx_sr  <= {tx_sr[6:0], 1'b0};
          end else if (bit_cnt != 3'd0) begin
            // the trailing edge after a byte boundary must not shift the freshly loaded byte
            tx_sr <= {tx_sr[6:0], 1'b0};
          end
        end

        if (sample_edge) begin
          rx_sr   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;

          if (bit_cnt == 3'd3 && (state == ST_RDUMMY || state == ST_RDATA)) begin
            reg_re <= 1'b1;
          end

          if (bit_cnt == 3'd7) begin
            case (state)
              ST_CMD: begin
                reg_addr <= rx_byte[6:0];
                tx_sr    <= DUMMY_BYTE;
                state    <= rx_byte[7] ? ST_WDATA : ST_RDUMMY;
              end
              ST_WDATA: begin
                reg_wdata <= rx_byte;
                reg_we    <= 1'b1;
                inc_pend  <= 1'b1;
                tx_sr     <= DUMMY_BYTE;
              end
              ST_RDUMMY: begin
                tx_sr <= rd_buf;
                state <= ST_RDATA;
              end
              ST_RDATA: begin
                tx_sr <= rd_buf;
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

endmodule
